gw_jtag_er_bridge: RTL and testbench

JTAG-to-register-bus bridge driven by the GW_JTAG user-instruction port ER1. Oversamples the TAP-side strobes in the system clock domain, runs a (1+ADDR_W+DATA_W)-bit DR shift engine, and turns each Update-DR into one read or write on a simple req/ack register bus with timeout. Sits between the GW_JTAG primitive and the SoC control-register block; ER2 is unused.

---
 rtl/gw_jtag_er_bridge_if.sv | 16 +
 rtl/gw_jtag_er_bridge.sv | 136 +++++++++++++
 tb/tb_gw_jtag_er_bridge.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gw_jtag_er_bridge_if.sv
// Register-bus handshake between the JTAG ER1 bridge (master) and the SoC register block (slave).
// The master holds req until the slave returns a single-cycle ack.
interface gw_jtag_er_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/gw_jtag_er_bridge.sv
// GW_JTAG ER1 to register-bus bridge: oversampled TAP strobes drive a DR shift engine,
// and each Update-DR launches one read or write with a timeout.
module gw_jtag_er_bridge #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tdi_i,
  input  logic tlr_i,
  input  logic shift_capture_i,
  input  logic update_i,
  input  logic enable_er1_i,
  output logic tdo_er1_o,
  gw_jtag_er_bridge_if.master bus
);

  localparam int W  = 1 + ADDR_W + DATA_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_next;

  logic [5:0]        meta, sync;
  logic              tck_s, tdi_s, tlr_s, sc_s, upd_s, en_s;
  logic              tck_h, upd_h;
  logic              tck_rise, update_rise;
  logic              capture, shift;
  logic              in_dr;
  logic [W-1:0]      sr;
  logic              tmo, ovr;
  logic              busy, accept, tmo_set, ovr_set;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [TW-1:0]     timer;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta  <= '0;
      sync  <= '0;
      tck_h <= 1'b0;
      upd_h <= 1'b0;
    end else begin
      meta  <= {tck_i, tdi_i, tlr_i, shift_capture_i, update_i, enable_er1_i};
      sync  <= meta;
      tck_h <= tck_s;
      upd_h <= upd_s & en_s;
    end
  end

  assign {tck_s, tdi_s, tlr_s, sc_s, upd_s, en_s} = sync;
  assign tck_rise    = tck_s & ~tck_h;
  assign update_rise = upd_s & en_s & ~upd_h;

  // A TLR in the same cycle as a capture edge wins, so the scan restarts cleanly.
  assign capture = tck_rise & en_s & sc_s & ~in_dr & ~tlr_s;
  assign shift   = tck_rise & en_s & sc_s & in_dr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_dr <= 1'b0;
      sr    <= '0;
      tmo   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (update_rise || tlr_s || !en_s)
        in_dr <= 1'b0;
      else if (capture)
        in_dr <= 1'b1;

      if (capture)
        sr <= {busy, tmo, ovr, {(ADDR_W-2){1'b0}}, rdata_q};
      else if (shift)
        sr <= {tdi_s, sr[W-1:1]};

      // Flag set beats the read-to-clear of a simultaneous capture.
      if (tmo_set)      tmo <= 1'b1;
      else if (capture) tmo <= 1'b0;

      if (ovr_set)      ovr <= 1'b1;
      else if (capture) ovr <= 1'b0;
    end
  end

  assign tdo_er1_o = sr[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (update_rise) state_next = WAIT;
      WAIT: if (bus.ack || timer == TLAST) state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == WAIT);
    accept  = (state == IDLE) && update_rise;
    tmo_set = (state == WAIT) && !bus.ack && (timer == TLAST);
    ovr_set = (state == WAIT) && update_rise;
    bus.req = (state == WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer   <= '0;
    end else if (accept) begin
      we_q    <= sr[W-1];
      addr_q  <= sr[W-2:DATA_W];
      wdata_q <= sr[DATA_W-1:0];
      timer   <= '0;
    end else if (state == WAIT) begin
      timer <= timer + 1'b1;
      if (bus.ack && !we_q)
        rdata_q <= bus.rdata;
    end
  end

  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_gw_jtag_er_bridge.sv
// Directed bench for gw_jtag_er_bridge: a table of DR-scan commands with expected bus
// activity and capture status, plus hand sequences for overrun, busy, TLR and reset.
module tb_gw_jtag_er_bridge;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int W       = 1 + ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0, tdi = 1'b0, tlr = 1'b0, sc = 1'b0, upd = 1'b0, en = 1'b0;
  logic tdo;

  gw_jtag_er_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  gw_jtag_er_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tck_i           (tck),
    .tdi_i           (tdi),
    .tlr_i           (tlr),
    .shift_capture_i (sc),
    .update_i        (upd),
    .enable_er1_i    (en),
    .tdo_er1_o       (tdo),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  int                tests = 0;
  int                failures = 0;
  int                ack_delay = 0;
  logic [DATA_W-1:0] resp_data = '0;
  bit                force_ack = 1'b0;
  int                req_count = 0;
  int                req_len = 0;
  logic              req_prev = 1'b0;
  logic              seen_we = 1'b0;
  logic [ADDR_W-1:0] seen_addr = '0;
  logic [DATA_W-1:0] seen_wdata = '0;

  // Register-block model: acks after ack_delay cycles of req (0 = never).
  always @(negedge clk) begin
    bus_if.ack = 1'b0;
    if (force_ack) begin
      bus_if.ack   = 1'b1;
      bus_if.rdata = resp_data;
    end else if (bus_if.req) begin
      if (!req_prev) begin
        req_count++;
        req_len    = 0;
        seen_we    = bus_if.we;
        seen_addr  = bus_if.addr;
        seen_wdata = bus_if.wdata;
      end
      req_len++;
      if (ack_delay > 0 && req_len == ack_delay) begin
        bus_if.ack   = 1'b1;
        bus_if.rdata = resp_data;
      end
    end
    req_prev = bus_if.req;
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                ack_delay;
    logic [DATA_W-1:0] resp;
    int                exp_len;
    logic              exp_tmo;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tckPulse();
    @(negedge clk); tck = 1'b1;
    repeat (8) @(negedge clk);
    tck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic captureAndShift(input logic [W-1:0] din, output logic [W-1:0] dout);
    sc = 1'b1;
    tckPulse();
    for (int i = 0; i < W; i++) begin
      dout[i] = tdo;
      tdi     = din[i];
      tckPulse();
    end
    sc = 1'b0;
  endtask

  task automatic updatePulse();
    @(negedge clk); upd = 1'b1;
    repeat (4) @(negedge clk);
    upd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tlrPulse();
    @(negedge clk); tlr = 1'b1;
    repeat (4) @(negedge clk);
    tlr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic captureOnly(output logic [W-1:0] dout);
    captureAndShift('0, dout);
    tlrPulse();
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (bus_if.req === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_req_drops"}, 64'(n < 200), 64'd1);
  endtask

  task automatic checkStatus(input string name, input logic [W-1:0] dout, input logic busy,
                             input logic tmo, input logic ovr, input logic [DATA_W-1:0] rdata);
    checkOutput({name, "_busy"},  64'(dout[W-1]), 64'(busy));
    checkOutput({name, "_tmo"},   64'(dout[W-2]), 64'(tmo));
    checkOutput({name, "_ovr"},   64'(dout[W-3]), 64'(ovr));
    checkOutput({name, "_zero"},  64'(dout[W-4:DATA_W]), 64'd0);
    checkOutput({name, "_rdata"}, 64'(dout[DATA_W-1:0]), 64'(rdata));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v, input logic ptmo, input logic [DATA_W-1:0] prd);
    logic [W-1:0] dout;
    int cnt0;
    captureAndShift({v.we, v.addr, v.data}, dout);
    checkStatus($sformatf("v%0d_cap", idx), dout, 1'b0, ptmo, 1'b0, prd);
    ack_delay = v.ack_delay;
    resp_data = v.resp;
    cnt0 = req_count;
    updatePulse();
    waitIdle($sformatf("v%0d", idx));
    checkOutput($sformatf("v%0d_req_count", idx), 64'(req_count - cnt0), 64'd1);
    checkOutput($sformatf("v%0d_we", idx),    64'(seen_we),    64'(v.we));
    checkOutput($sformatf("v%0d_addr", idx),  64'(seen_addr),  64'(v.addr));
    checkOutput($sformatf("v%0d_wdata", idx), 64'(seen_wdata), 64'(v.data));
    checkOutput($sformatf("v%0d_req_len", idx), 64'(req_len), 64'(v.exp_len));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0]      dout;
    logic              ptmo;
    logic [DATA_W-1:0] prd;
    int                cnt0;

    vecs[0] = '{1'b1, 7'h15, 32'hDEADBEEF, 3,  32'h0,        3,  1'b0, 32'h0};
    vecs[1] = '{1'b0, 7'h02, 32'h0,        3,  32'h12345678, 3,  1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 7'h7F, 32'h0,        0,  32'h0,        16, 1'b1, 32'h12345678};
    vecs[3] = '{1'b1, 7'h00, 32'h00000001, 1,  32'h0,        1,  1'b0, 32'h12345678};
    vecs[4] = '{1'b0, 7'h55, 32'h0,        16, 32'hA5A50F0F, 16, 1'b0, 32'hA5A50F0F};
    vecs[5] = '{1'b0, 7'h01, 32'h0,        15, 32'h0BADF00D, 15, 1'b0, 32'h0BADF00D};
    vecs[6] = '{1'b1, 7'h7F, 32'hFFFFFFFF, 2,  32'h11111111, 2,  1'b0, 32'h0BADF00D};

    repeat (4) @(negedge clk);
    checkOutput("reset_tdo",   64'(tdo),          64'd0);
    checkOutput("reset_req",   64'(bus_if.req),   64'd0);
    checkOutput("reset_we",    64'(bus_if.we),    64'd0);
    checkOutput("reset_addr",  64'(bus_if.addr),  64'd0);
    checkOutput("reset_wdata", 64'(bus_if.wdata), 64'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(negedge clk);

    ptmo = 1'b0;
    prd  = '0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i, vecs[i], ptmo, prd);
      ptmo = vecs[i].exp_tmo;
      prd  = vecs[i].exp_rdata;
    end
    captureOnly(dout);
    checkStatus("final_cap", dout, 1'b0, ptmo, 1'b0, prd);

    // Overrun: second update while the first read is still waiting for ack.
    captureAndShift({1'b0, 7'h10, 32'h0}, dout);
    checkStatus("ovr_pre", dout, 1'b0, 1'b0, 1'b0, 32'h0BADF00D);
    ack_delay = 12;
    resp_data = 32'h600DCAFE;
    cnt0 = req_count;
    @(negedge clk); upd = 1'b1;
    repeat (4) @(negedge clk); upd = 1'b0;
    repeat (4) @(negedge clk); upd = 1'b1;
    repeat (4) @(negedge clk); upd = 1'b0;
    repeat (4) @(negedge clk);
    waitIdle("ovr");
    checkOutput("ovr_req_len",  64'(req_len),   64'd12);
    checkOutput("ovr_addr",     64'(seen_addr), 64'h10);
    repeat (20) @(negedge clk);
    checkOutput("ovr_req_count", 64'(req_count - cnt0), 64'd1);
    captureOnly(dout);
    checkStatus("ovr_cap", dout, 1'b0, 1'b0, 1'b1, 32'h600DCAFE);
    captureOnly(dout);
    checkStatus("ovr_clr", dout, 1'b0, 1'b0, 1'b0, 32'h600DCAFE);

    // Capture while a request is outstanding shows busy; that request then times out.
    ack_delay = 0;
    cnt0 = req_count;
    updatePulse();
    captureAndShift('0, dout);
    checkStatus("busy_cap", dout, 1'b1, 1'b0, 1'b0, 32'h600DCAFE);
    tlrPulse();
    waitIdle("busy");
    checkOutput("busy_req_len",   64'(req_len), 64'(TIMEOUT));
    checkOutput("busy_req_count", 64'(req_count - cnt0), 64'd1);
    captureOnly(dout);
    checkStatus("tmo_cap", dout, 1'b0, 1'b1, 1'b0, 32'h600DCAFE);
    captureOnly(dout);
    checkStatus("tmo_clr", dout, 1'b0, 1'b0, 1'b0, 32'h600DCAFE);

    // TLR after 10 shifted bits aborts the scan; a fresh scan still works.
    cnt0 = req_count;
    sc = 1'b1;
    tckPulse();
    for (int i = 0; i < 10; i++) begin
      tdi = 1'b1;
      tckPulse();
    end
    sc = 1'b0;
    tlrPulse();
    repeat (10) @(negedge clk);
    checkOutput("tlr_no_req", 64'(req_count - cnt0), 64'd0);
    captureAndShift({1'b1, 7'h2A, 32'hC0FFEE11}, dout);
    checkStatus("tlr_cap", dout, 1'b0, 1'b0, 1'b0, 32'h600DCAFE);
    ack_delay = 2;
    updatePulse();
    waitIdle("tlr");
    checkOutput("tlr_req_count", 64'(req_count - cnt0), 64'd1);
    checkOutput("tlr_we",    64'(seen_we),    64'd1);
    checkOutput("tlr_addr",  64'(seen_addr),  64'h2A);
    checkOutput("tlr_wdata", 64'(seen_wdata), 64'hC0FFEE11);

    // Reset during WAIT, then a late ack that must be ignored.
    ack_delay = 0;
    captureAndShift({1'b0, 7'h33, 32'h0}, dout);
    cnt0 = req_count;
    updatePulse();
    checkOutput("rstw_req_before", 64'(bus_if.req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstw_req",  64'(bus_if.req),  64'd0);
    checkOutput("rstw_addr", 64'(bus_if.addr), 64'd0);
    checkOutput("rstw_tdo",  64'(tdo),         64'd0);
    rst = 1'b0;
    resp_data = 32'hCAFEF00D;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rstw_req_after",  64'(bus_if.req), 64'd0);
    checkOutput("rstw_req_count",  64'(req_count - cnt0), 64'd1);
    captureOnly(dout);
    checkStatus("rstw_cap", dout, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
